// File: rtl/sync_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_mem_if
//  Description : Request/response bundle between a requester and sync_mem.
//                The requester drives the strobe, direction, address and write
//                data; the memory returns read data and completion status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_mem_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              EN;
   logic              R_W;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] dataIn;
   logic [DATA_W-1:0] dataOut;
   logic              MFC;
   logic              ERR;
   logic              BUSY;

   modport master (
      output EN, R_W, address, dataIn,
      input  dataOut, MFC, ERR, BUSY
   );

   modport slave (
      input  EN, R_W, address, dataIn,
      output dataOut, MFC, ERR, BUSY
   );
endinterface
`default_nettype wire

// File: rtl/sync_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sync_mem
//  Description : Word-addressed memory with a fixed access latency and an
//                EN/MFC completion handshake. A request is latched on accept,
//                held for LATENCY wait cycles, performed, then MFC is held
//                until the requester drops EN. Out-of-range addresses raise
//                ERR instead of touching the array.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_mem #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 32,
   parameter int LATENCY = 2
) (
   input  wire logic  clk,
   input  wire logic  reset,
   sync_mem_if.slave  bus
);

   // Index width; a single-word array still needs a one-bit index.
   localparam int                c_idx_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                c_cnt_w   = 4;
   localparam logic [c_cnt_w-1:0] c_latency = c_cnt_w'(LATENCY);
   // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
   localparam logic [ADDR_W:0]   c_depth   = (ADDR_W + 1)'(DEPTH);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_wait = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;

   logic [c_cnt_w-1:0] r_cnt;
   logic               r_rw;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_data_out;
   logic               r_mfc;
   logic               r_err;
   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic               w_accept;
   logic               w_tick;
   logic               w_access;
   logic               w_release;
   logic               w_busy;
   logic               w_in_range;
   logic [c_idx_w-1:0] w_idx;

   // Range check happens on the full latched address; only then is the
   // truncated index meaningful.
   assign w_in_range = ({1'b0, r_addr} < c_depth);
   assign w_idx      = r_addr[c_idx_w-1:0];

   assign bus.dataOut = r_data_out;
   assign bus.MFC     = r_mfc;
   assign bus.ERR     = r_err;
   assign bus.BUSY    = w_busy;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: the wait state runs until the counter has drained to zero,
   // so the access lands LATENCY+1 edges after accept for every LATENCY.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_idle: begin
            if (bus.EN) begin
               w_next_state = c_wait;
            end
         end
         c_wait: begin
            if (r_cnt == '0) begin
               w_next_state = c_done;
            end
         end
         c_done: begin
            if (!bus.EN) begin
               w_next_state = c_idle;
            end
         end
         default: begin
            w_next_state = c_idle;
         end
      endcase
   end

   // Control strobes decoded from the current state.
   always_comb begin
      w_accept  = 1'b0;
      w_tick    = 1'b0;
      w_access  = 1'b0;
      w_release = 1'b0;
      w_busy    = (r_state != c_idle);
      case (r_state)
         c_idle: begin
            w_accept = bus.EN;
         end
         c_wait: begin
            w_access = (r_cnt == '0);
            w_tick   = (r_cnt != '0);
         end
         c_done: begin
            w_release = !bus.EN;
         end
         default: begin
            w_busy = 1'b1;
         end
      endcase
   end

   // Request latch, wait counter, array and registered response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_rw       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_data_out <= '0;
         r_mfc      <= 1'b0;
         r_err      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_rw    <= bus.R_W;
            r_addr  <= bus.address;
            r_wdata <= bus.dataIn;
            r_cnt   <= c_latency;
         end else if (w_tick) begin
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_access) begin
            r_mfc <= 1'b1;
            r_err <= !w_in_range;
            if (r_rw) begin
               // An erroneous read deliberately returns zero.
               r_data_out <= w_in_range ? r_mem[w_idx] : '0;
            end else if (w_in_range) begin
               r_mem[w_idx] <= r_wdata;
            end
         end

         if (w_release) begin
            r_mfc <= 1'b0;
            r_err <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sync_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_mem
//  Description : Self-checking bench for sync_mem: directed vector table,
//                hand-written reset / zero-latency sequences and randomized
//                requests checked against a plain array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_mem;

   localparam int c_lat = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sync_mem_if #(.DATA_W(16), .ADDR_W(16)) bus  ();
   sync_mem_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

   sync_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(32), .LATENCY(c_lat)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   sync_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(32), .LATENCY(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: array contents and the last value dataOut should hold.
   logic [15:0] m_mem [32];
   logic [15:0] m_dout;

   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [15:0] data;
      int          hold;
      logic [15:0] exp_dout;
      logic        exp_err;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 16'h0;
      m_dout = 16'h0;
   endtask

   task automatic model_apply(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                              output logic [15:0] dout, output logic err);
      err = (addr >= 16'd32);
      if (rw) begin
         m_dout = err ? 16'h0 : m_mem[addr[4:0]];
      end else if (!err) begin
         m_mem[addr[4:0]] = data;
      end
      dout = m_dout;
   endtask

   // Full handshake on the LATENCY=2 instance; starts with the FSM idle.
   task automatic run_req(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                          input int hold, input logic [15:0] exp_dout, input logic exp_err,
                          input string tag, input bit scramble);
      int n;
      bit seen;
      bus.EN = 1'b1; bus.R_W = rw; bus.address = addr; bus.dataIn = data;
      @(posedge clk); #1;
      chk({tag, "_busy_accept"}, 32'(bus.BUSY), 32'd1);
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         if (scramble) begin
            bus.EN      = 1'($urandom);
            bus.R_W     = 1'($urandom);
            bus.address = 16'($urandom);
            bus.dataIn  = 16'($urandom);
         end
         @(posedge clk); #1;
         n++;
         if (bus.MFC === 1'b1) seen = 1'b1;
      end
      bus.EN = 1'b1;
      if (!seen) begin
         chk({tag, "_mfc_timeout"}, 32'(bus.MFC), 32'd1);
      end else begin
         chk({tag, "_latency"}, 32'(n), 32'(c_lat + 1));
         chk({tag, "_dout"}, 32'(bus.dataOut), 32'(exp_dout));
         chk({tag, "_err"}, 32'(bus.ERR), 32'(exp_err));
         for (int h = 0; h < hold; h++) begin
            bus.address = 16'($urandom);
            bus.dataIn  = 16'($urandom);
            bus.R_W     = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_mfc"}, 32'(bus.MFC), 32'd1);
            chk({tag, "_hold_busy"}, 32'(bus.BUSY), 32'd1);
            chk({tag, "_hold_dout"}, 32'(bus.dataOut), 32'(exp_dout));
         end
      end
      bus.EN = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_rel_mfc"}, 32'(bus.MFC), 32'd0);
      chk({tag, "_rel_busy"}, 32'(bus.BUSY), 32'd0);
      chk({tag, "_rel_err"}, 32'(bus.ERR), 32'd0);
      chk({tag, "_rel_dout"}, 32'(bus.dataOut), 32'(exp_dout));
   endtask

   // Handshake on the LATENCY=0 instance: completion one edge after accept.
   task automatic run_req0(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                           input logic [15:0] exp_dout, input string tag);
      bus0.EN = 1'b1; bus0.R_W = rw; bus0.address = addr; bus0.dataIn = data;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk({tag, "_mfc"}, 32'(bus0.MFC), 32'd1);
      chk({tag, "_dout"}, 32'(bus0.dataOut), 32'(exp_dout));
      chk({tag, "_err"}, 32'(bus0.ERR), 32'd0);
      bus0.EN = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_rel_mfc"}, 32'(bus0.MFC), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic        e;
      logic        rw;
      logic [15:0] a;
      logic [15:0] wd;

      tbl[0]  = '{1'b0, 16'd5,  16'hBEEF, 0,  16'h0000, 1'b0};
      tbl[1]  = '{1'b1, 16'd5,  16'h0000, 0,  16'hBEEF, 1'b0};
      tbl[2]  = '{1'b0, 16'd40, 16'h1234, 0,  16'hBEEF, 1'b1};
      tbl[3]  = '{1'b1, 16'd40, 16'h0000, 0,  16'h0000, 1'b1};
      tbl[4]  = '{1'b1, 16'd8,  16'h0000, 0,  16'h0000, 1'b0};
      tbl[5]  = '{1'b0, 16'd31, 16'h5A5A, 10, 16'h0000, 1'b0};
      tbl[6]  = '{1'b1, 16'd31, 16'h0000, 0,  16'h5A5A, 1'b0};
      tbl[7]  = '{1'b1, 16'd32, 16'h0000, 0,  16'h0000, 1'b1};
      tbl[8]  = '{1'b0, 16'd0,  16'hFFFF, 2,  16'h0000, 1'b0};
      tbl[9]  = '{1'b1, 16'd0,  16'h0000, 10, 16'hFFFF, 1'b0};
      tbl[10] = '{1'b0, 16'd40, 16'h7777, 0,  16'hFFFF, 1'b1};
      tbl[11] = '{1'b1, 16'd5,  16'h0000, 1,  16'hBEEF, 1'b0};

      bus.EN  = 1'b0; bus.R_W  = 1'b0; bus.address  = '0; bus.dataIn  = '0;
      bus0.EN = 1'b0; bus0.R_W = 1'b0; bus0.address = '0; bus0.dataIn = '0;
      reset = 1'b0;
      model_reset();
      #1;
      chk("reset_mfc",  32'(bus.MFC),     32'd0);
      chk("reset_err",  32'(bus.ERR),     32'd0);
      chk("reset_busy", 32'(bus.BUSY),    32'd0);
      chk("reset_dout", 32'(bus.dataOut), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Zero-latency instance.
      run_req0(1'b1, 16'd0, 16'h0000, 16'h0000, "l0_rd0");
      run_req0(1'b0, 16'd2, 16'h1357, 16'h0000, "l0_wr2");
      run_req0(1'b1, 16'd2, 16'h0000, 16'h1357, "l0_rd2");

      // Directed vector table.
      for (int i = 0; i < 12; i++) begin
         model_apply(tbl[i].rw, tbl[i].addr, tbl[i].data, d, e);
         run_req(tbl[i].rw, tbl[i].addr, tbl[i].data, tbl[i].hold,
                 tbl[i].exp_dout, tbl[i].exp_err, $sformatf("vec%0d", i), (i >= 2));
      end

      // Reset during WAIT abandons a pending write and clears everything.
      bus.EN = 1'b1; bus.R_W = 1'b0; bus.address = 16'd3; bus.dataIn = 16'hAAAA;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rstw_busy_before", 32'(bus.BUSY), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rstw_mfc",  32'(bus.MFC),     32'd0);
      chk("rstw_busy", 32'(bus.BUSY),    32'd0);
      chk("rstw_dout", 32'(bus.dataOut), 32'd0);
      chk("rstw_err",  32'(bus.ERR),     32'd0);
      bus.EN = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      model_apply(1'b1, 16'd3, 16'h0, d, e);
      run_req(1'b1, 16'd3, 16'h0, 0, d, e, "rstw_rd3", 1'b0);
      model_apply(1'b1, 16'd5, 16'h0, d, e);
      run_req(1'b1, 16'd5, 16'h0, 0, d, e, "rstw_rd5", 1'b0);

      // Randomized requests against the model.
      for (int i = 0; i < 80; i++) begin
         rw = (i < 20) ? 1'b0 : 1'($urandom);
         a  = 16'($urandom_range(0, 39));
         wd = 16'($urandom);
         model_apply(rw, a, wd, d, e);
         run_req(rw, a, wd, int'($urandom_range(0, 3)), d, e,
                 $sformatf("rnd%0d", i), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
